// File: rtl/btn_reader.sv
// btn_reader: synchronises raw push-button pins, debounces each one, produces
// level and one-cycle edge outputs, and queues press/release events behind a
// valid/ready handshake.
// Build option: define BTN_READER_RELEASE_EV_EN to also queue release events
// (reported with ev_release = 1). Without it only presses are queued and
// ev_release stays 0; btn_level and release_pulse behave the same either way.
module btn_reader #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int IDX_W           = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] press_pulse,
  output logic [NUM_BTN-1:0] release_pulse,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [IDX_W-1:0]   ev_idx,
  output logic               ev_release,
  output logic               ev_overflow
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Pressed = 1 from here on, whatever the board wiring.
  logic [NUM_BTN-1:0] btn_norm;
  assign btn_norm = BTN_ACTIVE_LOW ? ~btn_in : btn_in;

  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] press_q;
  logic [NUM_BTN-1:0] rel_q;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];

  logic [NUM_BTN-1:0] pend_press_q;
  logic [NUM_BTN-1:0] pend_press_d;
  logic [NUM_BTN-1:0] pend_rel_q;
  logic [NUM_BTN-1:0] pend_rel_d;
  logic [NUM_BTN-1:0] pick_oh_d;
  logic [NUM_BTN-1:0] consume_press_d;
`ifdef BTN_READER_RELEASE_EV_EN
  logic [NUM_BTN-1:0] consume_rel_d;
`endif
  logic               found_d;
  logic [IDX_W-1:0]   pick_idx_d;
  logic               pick_rel_d;
  logic               load_d;
  logic               overflow_d;

  logic               ev_valid_q;
  logic [IDX_W-1:0]   ev_idx_q;
  logic               ev_release_q;
  logic               ev_overflow_q;

  // Two-flop synchroniser plus per-button debounce counter and edge pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= btn_norm;
      sync2_q <= sync1_q;
      for (int i = 0; i < NUM_BTN; i++) begin
        press_q[i] <= 1'b0;
        rel_q[i]   <= 1'b0;
        if (sync2_q[i] == level_q[i]) begin
          // Any bounce back to the current level restarts the count.
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          level_q[i] <= sync2_q[i];
          cnt_q[i]   <= '0;
          press_q[i] <= sync2_q[i];
          rel_q[i]   <= ~sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Pick the lowest pending index; a pending press beats a release there.
  always_comb begin
    found_d    = 1'b0;
    pick_idx_d = '0;
    pick_rel_d = 1'b0;
    pick_oh_d  = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pend_press_q[i] || pend_rel_q[i]) begin
        found_d      = 1'b1;
        pick_idx_d   = IDX_W'(i);
        pick_rel_d   = ~pend_press_q[i];
        pick_oh_d    = '0;
        pick_oh_d[i] = 1'b1;
      end else begin
        found_d = found_d;
      end
    end
  end

  // Pending-bit next state: a new pulse always wins over a same-cycle consume,
  // and a pulse landing on a still-pending bit merges and flags overflow.
  always_comb begin
    load_d          = ~ev_valid_q | ev_ready;
    consume_press_d = (load_d && found_d) ? (pick_oh_d & pend_press_q) : '0;
    pend_press_d    = press_q | (pend_press_q & ~consume_press_d);
`ifdef BTN_READER_RELEASE_EV_EN
    consume_rel_d   = (load_d && found_d) ? (pick_oh_d & ~pend_press_q) : '0;
    pend_rel_d      = rel_q | (pend_rel_q & ~consume_rel_d);
    overflow_d      = |((press_q & pend_press_q & ~consume_press_d) |
                        (rel_q & pend_rel_q & ~consume_rel_d));
`else
    pend_rel_d      = '0;
    overflow_d      = |(press_q & pend_press_q & ~consume_press_d);
`endif
  end

  // Pending bits and the event output register (holds while stalled).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_press_q  <= '0;
      pend_rel_q    <= '0;
      ev_valid_q    <= 1'b0;
      ev_idx_q      <= '0;
      ev_release_q  <= 1'b0;
      ev_overflow_q <= 1'b0;
    end else begin
      pend_press_q  <= pend_press_d;
      pend_rel_q    <= pend_rel_d;
      ev_overflow_q <= overflow_d;
      if (load_d) begin
        ev_valid_q   <= found_d;
        ev_idx_q     <= pick_idx_d;
        ev_release_q <= pick_rel_d;
      end
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign ev_valid      = ev_valid_q;
  assign ev_idx        = ev_idx_q;
  assign ev_release    = ev_release_q;
  assign ev_overflow   = ev_overflow_q;

endmodule

// File: tb/tb_btn_reader.sv
// Self-checking bench for btn_reader: directed scenarios followed by random
// button/ready activity, all compared each cycle against a window-based
// behavioural model (a level flips once the synchronised input has shown the
// opposite value for DB consecutive samples).
module tb_btn_reader;

  localparam int NB = 4;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NB-1:0] btn_in = '0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] press_pulse;
  logic [NB-1:0] release_pulse;
  logic          ev_valid;
  logic          ev_ready = 1'b1;
  logic [1:0]    ev_idx;
  logic          ev_release;
  logic          ev_overflow;

  btn_reader #(
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(DB),
    .BTN_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_idx(ev_idx),
    .ev_release(ev_release),
    .ev_overflow(ev_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [NB-1:0] samp [0:DB+1];   // samp[0] = btn_in at latest edge
  logic [NB-1:0] m_level, m_press, m_rel, m_pp, m_pr;
  logic          m_valid, m_relev, m_ovf;
  logic [1:0]    m_idx;

  logic [2:0]    got_q [$];       // {release, idx} per handshake seen on DUT
  int            press_cnt [NB];
  int            ovf_cnt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k <= DB + 1; k++) samp[k] = '0;
    m_level = '0; m_press = '0; m_rel = '0; m_pp = '0; m_pr = '0;
    m_valid = 1'b0; m_relev = 1'b0; m_ovf = 1'b0; m_idx = 2'd0;
  endtask

  task automatic model_edge();
    logic          load, found, crel, novf, all_diff;
    int            ci;
    logic [NB-1:0] nl, np, nr, npp, npr;
    load  = !m_valid || ev_ready;
    found = 1'b0; ci = 0; crel = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (!found && (m_pp[i] || m_pr[i])) begin
        found = 1'b1; ci = i; crel = !m_pp[i];
      end
    end
    npp = m_pp; npr = m_pr; novf = 1'b0;
    if (load && found) begin
      if (crel) npr[ci] = 1'b0;
      else      npp[ci] = 1'b0;
    end
    for (int i = 0; i < NB; i++) begin
      if (m_press[i]) begin
        if (npp[i]) novf = 1'b1;
        npp[i] = 1'b1;
      end
`ifdef BTN_READER_RELEASE_EV_EN
      if (m_rel[i]) begin
        if (npr[i]) novf = 1'b1;
        npr[i] = 1'b1;
      end
`endif
    end
    if (load) begin
      m_valid = found; m_idx = 2'(ci); m_relev = crel;
    end
    for (int k = DB + 1; k > 0; k--) samp[k] = samp[k-1];
    samp[0] = btn_in;
    nl = m_level; np = '0; nr = '0;
    for (int i = 0; i < NB; i++) begin
      all_diff = 1'b1;
      for (int k = 2; k <= DB + 1; k++) begin
        if (samp[k][i] == m_level[i]) all_diff = 1'b0;
      end
      if (all_diff) begin
        nl[i] = ~m_level[i]; np[i] = nl[i]; nr[i] = ~nl[i];
      end
    end
    m_level = nl; m_press = np; m_rel = nr; m_pp = npp; m_pr = npr; m_ovf = novf;
  endtask

  task automatic check_all();
    chk("level",   16'(btn_level),     16'(m_level));
    chk("press",   16'(press_pulse),   16'(m_press));
    chk("release", 16'(release_pulse), 16'(m_rel));
    chk("valid",   16'(ev_valid),      16'(m_valid));
    chk("ovf",     16'(ev_overflow),   16'(m_ovf));
    if (m_valid) begin
      chk("idx",   16'(ev_idx),     16'(m_idx));
      chk("evrel", 16'(ev_release), 16'(m_relev));
    end
  endtask

  task automatic step();
    if (ev_valid && ev_ready) got_q.push_back({ev_release, ev_idx});
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    check_all();
    for (int i = 0; i < NB; i++) if (press_pulse[i]) press_cnt[i]++;
    if (ev_overflow) ovf_cnt++;
  endtask

  task automatic clear_counts();
    got_q.delete();
    for (int i = 0; i < NB; i++) press_cnt[i] = 0;
    ovf_cnt = 0;
  endtask

  int n_idx1;

  initial begin
    model_clear();
    clear_counts();

    // Reset values with all buttons held
    btn_in = 4'b1111; ev_ready = 1'b1; reset = 1'b1;
    repeat (3) step();
    chk("rst_out", 16'({btn_level, press_pulse, release_pulse, ev_valid, ev_overflow, ev_idx, ev_release}), 16'h0);
    reset = 1'b0;
    clear_counts();
    repeat (5) step();
    chk("rst_lvl5", 16'(btn_level), 16'h0);
    step();
    chk("rst_lvl6", 16'(btn_level), 16'hF);
    repeat (10) step();
    chk("rst_evcnt", 16'(got_q.size()), 16'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("rst_ev", 16'(got_q[i]), 16'(i));

    // Release everything and let any release events drain
    btn_in = 4'b0000;
    repeat (14) step();

    // Clean press on button 2
    clear_counts();
    btn_in = 4'b0100;
    repeat (5) step();
    chk("clean_lvl5", 16'(btn_level[2]), 16'd0);
    step();
    chk("clean_lvl6", 16'(btn_level[2]), 16'd1);
    chk("clean_pp6", 16'(press_pulse), 16'h4);
    step();
    chk("clean_pp7", 16'(press_pulse), 16'h0);
    chk("clean_v7", 16'(ev_valid), 16'd0);
    step();
    chk("clean_v8", 16'(ev_valid), 16'd1);
    chk("clean_idx", 16'(ev_idx), 16'd2);
    chk("clean_rel", 16'(ev_release), 16'd0);
    step();
    chk("clean_v9", 16'(ev_valid), 16'd0);

    // Bounce on button 1: toggles every 2 cycles, then holds pressed
    clear_counts();
    for (int c = 0; c < 12; c++) begin
      btn_in[1] = ((c / 2) % 2 == 0);
      step();
      chk("bounce_lvl", 16'(btn_level[1]), 16'd0);
    end
    btn_in[1] = 1'b1;
    repeat (12) step();
    chk("bounce_lvl_end", 16'(btn_level[1]), 16'd1);
    chk("bounce_pulses", 16'(press_cnt[1]), 16'd1);
    n_idx1 = 0;
    foreach (got_q[i]) if (got_q[i] == 3'b001) n_idx1++;
    chk("bounce_events", 16'(n_idx1), 16'd1);
    chk("bounce_evtotal", 16'(got_q.size()), 16'd1);

    // Arbitration: buttons 0 and 3 rise together with the consumer stalled
    ev_ready = 1'b0;
    btn_in = 4'b1111;
    repeat (8) step();
    chk("arb_v", 16'(ev_valid), 16'd1);
    chk("arb_idx0", 16'(ev_idx), 16'd0);
    repeat (3) step();
    chk("arb_hold", 16'(ev_idx), 16'd0);
    ev_ready = 1'b1; step(); ev_ready = 1'b0;
    chk("arb_v3", 16'(ev_valid), 16'd1);
    chk("arb_idx3", 16'(ev_idx), 16'd3);
    step();
    chk("arb_hold3", 16'(ev_idx), 16'd3);
    ev_ready = 1'b1; step(); ev_ready = 1'b0;
    chk("arb_empty", 16'(ev_valid), 16'd0);
    step();

    // Overflow: stalled consumer, btn1 press/release/press, btn2 press/release/press
    ev_ready = 1'b1;
    btn_in = 4'b0000;
    repeat (14) step();
    clear_counts();
    ev_ready = 1'b0;
    btn_in = 4'b0010; repeat (8) step();
    btn_in = 4'b0000; repeat (8) step();
    btn_in = 4'b0010; repeat (8) step();
    btn_in = 4'b0110; repeat (8) step();
    btn_in = 4'b0010; repeat (8) step();
    btn_in = 4'b0110; repeat (8) step();
    chk("ovf_count", 16'(ovf_cnt), 16'd1);
    ev_ready = 1'b1;
    repeat (10) step();
    // The first btn1 press sits in the output slot; the second merges into
    // nothing because its pending bit was free, and press sorts before release.
`ifdef BTN_READER_RELEASE_EV_EN
    chk("ovf_drain_n", 16'(got_q.size()), 16'd5);
    if (got_q.size() == 5) begin
      chk("ovf_d0", 16'(got_q[0]), 16'(3'b001));
      chk("ovf_d1", 16'(got_q[1]), 16'(3'b001));
      chk("ovf_d2", 16'(got_q[2]), 16'(3'b101));
      chk("ovf_d3", 16'(got_q[3]), 16'(3'b010));
      chk("ovf_d4", 16'(got_q[4]), 16'(3'b110));
    end
`else
    chk("ovf_drain_n", 16'(got_q.size()), 16'd3);
    if (got_q.size() == 3) begin
      chk("ovf_d0", 16'(got_q[0]), 16'(3'b001));
      chk("ovf_d1", 16'(got_q[1]), 16'(3'b001));
      chk("ovf_d2", 16'(got_q[2]), 16'(3'b010));
    end
`endif

    // Reset mid-handshake with a debounce count in flight
    ev_ready = 1'b0;
    btn_in = 4'b0111;
    repeat (8) step();
    chk("mid_v", 16'(ev_valid), 16'd1);
    btn_in = 4'b1111;
    repeat (4) step();
    reset = 1'b1;
    #1;
    model_clear();
    check_all();
    chk("mid_rst_out", 16'({btn_level, press_pulse, release_pulse, ev_valid, ev_overflow, ev_idx, ev_release}), 16'h0);
    repeat (2) step();
    btn_in = 4'b0000;
    ev_ready = 1'b1;
    reset = 1'b0;
    clear_counts();
    repeat (15) step();
    chk("mid_no_stale", 16'(got_q.size()), 16'd0);

    // Random button activity with random consumer back-pressure
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NB; i++) begin
        if ($urandom_range(7) == 0) btn_in[i] = ~btn_in[i];
      end
      ev_ready = 1'($urandom_range(1));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
